// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with pin synchronisation, clock deglitch, framing/parity checks and timeout.
`timescale 1ns/1ps
module ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       event_ready,
  output logic [7:0] event_data,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] clk_sync_q, dat_sync_q;
  logic filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;
  logic ready_q, ready_d, perr_q, perr_d, ferr_q, ferr_d;
  logic fe, dat, term, timeout;
  // fe fires in the same cycle the filtered level is about to drop, so dat is sampled alongside it
  assign fe = filt_q && !clk_sync_q[1] && filt_cnt_q == FW'(FILTER_LEN - 1);
  assign dat = dat_sync_q[1];
  assign term = timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign timeout = state_q != IDLE && term && !fe;
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clock};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q     <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    data_d    = data_q;
    timer_d   = (state_q == IDLE || fe) ? '0 : (term ? timer_q : timer_q + 1'b1);
    ready_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else if (fe) begin
      case (state_q)
        IDLE: begin
          state_d   = dat ? IDLE : DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          if (bit_cnt_q == 4'd8) begin
            parity_d = dat;
            state_d  = STOP;
          end else begin
            shift_d   = {dat, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        STOP: begin
          state_d = IDLE;
          ferr_d  = !dat;
          perr_d  = dat && !(^{shift_q, parity_q});
          ready_d = dat && (^{shift_q, parity_q});
          data_d  = ready_d ? shift_q : data_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      data_q    <= '0;
      timer_q   <= '0;
      ready_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      data_q    <= data_d;
      timer_q   <= timer_d;
      ready_q   <= ready_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end
  assign event_ready = ready_q;
  assign event_data  = data_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: randomized PS/2 frames with a queue scoreboard; a monitor pops expectations on every DUT pulse.
`timescale 1ns/1ps
module tb_ps2_rx;
  localparam int TO = 600;
  typedef struct packed {logic [2:0] kind; logic [7:0] data;} exp_t;
  logic clk = 1'b0, rst = 1'b1, ps2_clock = 1'b1, ps2_data = 1'b1;
  logic event_ready, parity_err, frame_err;
  logic [7:0] event_data;
  exp_t q[$];
  exp_t m_e;
  logic [2:0] m_k;
  logic [7:0] last_good = 8'h00;
  int vectors = 0, errors = 0;
  ps2_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .event_ready(event_ready), .event_data(event_data),
    .parity_err(parity_err), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // kind encoding {frame_err, parity_err, event_ready}
  always @(negedge clk) begin
    if (!rst && (event_ready || parity_err || frame_err)) begin
      m_k = {frame_err, parity_err, event_ready};
      if (q.size() == 0) begin
        check("unexpected pulse", {29'd0, m_k}, 32'd0);
      end else begin
        m_e = q.pop_front();
        check("pulse kind", {29'd0, m_k}, {29'd0, m_e.kind});
        if (m_e.kind == 3'b001) last_good = m_e.data;
        check("event_data", {24'd0, event_data}, {24'd0, last_good});
      end
      @(negedge clk);
      check("pulse width", {29'd0, frame_err, parity_err, event_ready}, 32'd0);
    end
  end
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b, input int h, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cycles(h / 2);
      ps2_clock = 1'b0;
      wait_cycles(2);
      ps2_clock = 1'b1;
      wait_cycles(h - h / 2 - 2);
    end else wait_cycles(h);
    ps2_clock = 1'b0;
    if (glitch) begin
      wait_cycles(h / 2);
      ps2_clock = 1'b1;
      wait_cycles(2);
      ps2_clock = 1'b0;
      wait_cycles(h - h / 2 - 2);
    end else wait_cycles(h);
    ps2_clock = 1'b1;
  endtask
  task automatic wait_drain(input int n);
    for (int i = 0; i < n && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", q.size(), 32'd0);
  endtask
  // err: 0 good, 1 bad parity, 2 stop bit 0
  task automatic send_frame(input logic [7:0] b, input int err, input int h, input bit glitch);
    exp_t e;
    logic [10:0] f;
    e.kind = (err == 0) ? 3'b001 : (err == 1) ? 3'b010 : 3'b100;
    e.data = b;
    q.push_back(e);
    f = {(err != 2), (~^b) ^ (err == 1), b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], h, glitch);
    ps2_data = 1'b1;
    wait_cycles(3 * h);
    wait_drain(40);
  endtask
  task automatic check_reset_outputs();
    check("rst event_ready", {31'd0, event_ready}, 32'd0);
    check("rst event_data", {24'd0, event_data}, 32'd0);
    check("rst parity_err", {31'd0, parity_err}, 32'd0);
    check("rst frame_err", {31'd0, frame_err}, 32'd0);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    logic [7:0] tb_byte;
    wait_cycles(5);
    check_reset_outputs();
    rst = 1'b0;
    wait_cycles(5);
    send_frame(8'h1C, 0, 20, 1'b0);
    send_frame(8'hF0, 0, 20, 1'b0);
    send_frame(8'h1C, 0, 20, 1'b0);
    send_frame(8'h1C, 1, 20, 1'b0);
    send_frame(8'h5A, 2, 20, 1'b0);
    send_frame(8'h29, 0, 20, 1'b0);
    e.kind = 3'b100;
    e.data = 8'h00;
    q.push_back(e);
    tb_byte = 8'hA5;
    send_bit(1'b0, 20, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(tb_byte[i], 20, 1'b0);
    ps2_data = 1'b1;
    wait_drain(TO + 100);
    send_frame(8'h76, 0, 20, 1'b0);
    send_frame(8'h66, 0, 20, 1'b1);
    send_bit(1'b1, 20, 1'b0);
    wait_cycles(40);
    send_frame(8'h3B, 0, 18, 1'b0);
    send_bit(1'b0, 20, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(tb_byte[i], 20, 1'b0);
    rst = 1'b1;
    last_good = 8'h00;
    wait_cycles(4);
    check_reset_outputs();
    rst = 1'b0;
    wait_cycles(10);
    check_reset_outputs();
    send_frame(8'h45, 0, 20, 1'b0);
    for (int n = 0; n < 30; n++) begin
      int r;
      r = $urandom_range(0, 5);
      send_frame(8'($urandom), (r == 0) ? 1 : (r == 1) ? 2 : 0,
                 $urandom_range(16, 30), 1'($urandom_range(0, 1)));
    end
    wait_cycles(20);
    check("queue empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
